// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset and lock sequencer, clocked from the free-running
// reference oscillator rather than from the PLL output.
//
// Sequence: pulse PLL reset, wait for lock with a timeout, require lock to
// hold for a stability window, wait a further hold window, then release the
// reset of the PLL-clocked system. Losing lock at any point after the
// PLL reset pulse returns to waiting for lock. A timeout re-pulses the PLL
// reset and counts the failure.
//
// Ports:
//   clk          in   reference clock, all logic on its rising edge
//   resetn       in   asynchronous active-low reset for the whole block
//   pll_lock_i   in   PLL LOCK, asynchronous to clk
//   pll_reset_o  out  PLL RESET, active high
//   sys_resetn_o out  active-low reset for the PLL-clocked system (registered)
//   locked_o     out  high only while the sequencer is in RUN
//   fail_cnt_o   out  lock timeouts since resetn, saturating at 15
module pll_rst_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned HOLD_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock_i,
  output logic       pll_reset_o,
  output logic       sys_resetn_o,
  output logic       locked_o,
  output logic [3:0] fail_cnt_o
);

  // One shared counter, wide enough for the largest terminal count.
  localparam int unsigned MAX_AB  = (PLL_RST_CYCLES > HOLD_CYCLES) ? PLL_RST_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } state_e;

  // Lock synchronizer; lock_s is the only view of lock the FSM uses.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   lock_s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock_i};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pll_reset_q;
  logic             sys_resetn_q;
  logic             locked_q;
  logic [3:0]       fail_q;

  // Outputs are registered alongside the state so each one changes on the
  // same edge as the transition that defines it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      pll_reset_q  <= 1'b1;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 4'd0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        WAIT_LOCK: begin
          // Lock is tested before the timeout so a simultaneous lock wins.
          if (lock_s) begin
            state_q <= STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TMO_LAST) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            if (fail_q != 4'hF) begin
              fail_q <= fail_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STB_LAST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        HOLD: begin
          if (!lock_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q      <= RUN;
            cnt_q        <= '0;
            sys_resetn_q <= 1'b1;
            locked_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        RUN: begin
          if (!lock_s) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            sys_resetn_q <= 1'b0;
            locked_q     <= 1'b0;
          end
        end

        default: begin
          // Unused encodings recover through a fresh PLL reset pulse.
          state_q      <= PLL_RST;
          cnt_q        <= '0;
          pll_reset_q  <= 1'b1;
          sys_resetn_q <= 1'b0;
          locked_q     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset_o  = pll_reset_q;
  assign sys_resetn_o = sys_resetn_q;
  assign locked_o     = locked_q;
  assign fail_cnt_o   = fail_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with small parameters:
// SYNC_STAGES=2, PLL_RST_CYCLES=3, LOCK_TIMEOUT=32, STABLE_CYCLES=8,
// HOLD_CYCLES=4. Inputs change 1 ns after a rising edge; outputs are
// sampled at that same point.
module tb_pll_rst_seq;

  logic       clk;
  logic       resetn;
  logic       pll_lock_i;
  logic       pll_reset_o;
  logic       sys_resetn_o;
  logic       locked_o;
  logic [3:0] fail_cnt_o;

  int checks;
  int failures;

  pll_rst_seq #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(3),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .HOLD_CYCLES   (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pll_lock_i  (pll_lock_i),
    .pll_reset_o (pll_reset_o),
    .sys_resetn_o(sys_resetn_o),
    .locked_o    (locked_o),
    .fail_cnt_o  (fail_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return pll_reset_o;
      1:       return sys_resetn_o;
      default: return locked_o;
    endcase
  endfunction

  // Count rising edges until the selected output equals val (bounded).
  task automatic wait_sig(input int sel, input logic val, output int n);
    n = 0;
    while (get_sig(sel) !== val && n < 200) begin
      tick();
      n++;
    end
    if (get_sig(sel) !== val) n = 9999;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    pll_lock_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pll_reset", pll_reset_o, 1);
    chk("rst_sys_resetn", sys_resetn_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_fail_cnt", fail_cnt_o, 0);

    // No lock: 3-cycle pulse, 32-cycle wait, timeout re-pulse
    resetn = 1'b1;
    wait_sig(0, 1'b0, n);
    chk("pulse1_len", n, 3);
    wait_sig(0, 1'b1, n);
    chk("wait_lock_len", n, 32);
    chk("fail_after_tmo", fail_cnt_o, 1);
    wait_sig(0, 1'b0, n);
    chk("pulse2_len", n, 3);

    // Lock at WAIT_LOCK cycle 5: release 14 +/- 1 cycles later
    do_reset();
    wait_sig(0, 1'b0, n);
    repeat (5) tick();
    pll_lock_i = 1'b1;
    tick();
    chk("stable_sys_low", sys_resetn_o, 0);
    wait_sig(1, 1'b1, n);
    chk("release_latency_ok", (n + 1 >= 13 && n + 1 <= 15), 1);
    chk("release_locked", locked_o, 1);
    chk("release_pll_reset", pll_reset_o, 0);
    chk("release_fail_cnt", fail_cnt_o, 0);

    // Timeout and lock_s rising on the same edge: lock wins
    pll_lock_i = 1'b0;
    do_reset();
    wait_sig(0, 1'b0, n);
    repeat (29) tick();
    pll_lock_i = 1'b1;
    repeat (3) tick();
    chk("tie_pll_reset", pll_reset_o, 0);
    chk("tie_fail_cnt", fail_cnt_o, 0);
    wait_sig(1, 1'b1, n);
    chk("tie_reaches_run", (n > 0 && n < 20), 1);

    // Lock_s drops at STABLE count 6 for 2 cycles: sequence restarts
    pll_lock_i = 1'b0;
    do_reset();
    wait_sig(0, 1'b0, n);
    pll_lock_i = 1'b1;
    repeat (7) tick();
    pll_lock_i = 1'b0;
    repeat (2) tick();
    pll_lock_i = 1'b1;
    wait_sig(1, 1'b1, n);
    chk("restart_latency_ok", (n >= 13 && n <= 16), 1);
    chk("restart_fail_cnt", fail_cnt_o, 0);

    // Lock loss in RUN: outputs drop on the 3rd edge
    pll_lock_i = 1'b0;
    repeat (2) tick();
    chk("run_drop_e2_sys", sys_resetn_o, 1);
    tick();
    chk("run_drop_e3_sys", sys_resetn_o, 0);
    chk("run_drop_e3_locked", locked_o, 0);
    pll_lock_i = 1'b1;
    wait_sig(1, 1'b1, n);
    chk("relock_latency_ok", (n >= 13 && n <= 15), 1);
    chk("relock_fail_cnt", fail_cnt_o, 0);

    // 20 timeouts: fail count saturates at 15
    pll_lock_i = 1'b0;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      wait_sig(0, 1'b0, n);
      wait_sig(0, 1'b1, n);
      chk($sformatf("fail_sat_%0d", i), fail_cnt_o, (i < 15) ? i : 15);
    end

    // Asynchronous reset in RUN between clock edges
    pll_lock_i = 1'b1;
    wait_sig(1, 1'b1, n);
    chk("pre_async_sys", sys_resetn_o, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_pll_reset", pll_reset_o, 1);
    chk("async_sys_resetn", sys_resetn_o, 0);
    chk("async_locked", locked_o, 0);
    chk("async_fail_cnt", fail_cnt_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
